// File: rtl/core_apb_bridge_pkg.sv
// Shared types and constants for the core-to-APB3 bridge.
package core_apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [3:0]  BE_FULL   = 4'hF;
  localparam logic [31:0] RDATA_ERR = 32'h0;

endpackage

// File: rtl/core_apb_bridge_apb_watchdog_cnt.sv
// PREADY watchdog: counts ACCESS wait cycles and flags the cycle that reaches the limit.
module apb_watchdog_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires on the wait cycle whose increment would bring the count to the limit.
  assign expired_o = en_i && (cnt == LAST);

endmodule

// File: rtl/core_apb_bridge.sv
// Single-outstanding req/gnt/rvalid core bus to APB3 master, with BE check and PREADY watchdog.
module core_apb_bridge
  import core_apb_bridge_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          STRICT_BE      = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  // Handshake: a request transfers when req_i && gnt_o in the same cycle; the core holds
  // req_i and its payload until then. Exactly one rvalid_o pulse answers each grant.

  state_e state;
  logic   be_reject;
  logic   wd_clear;
  logic   wd_en;
  logic   wd_expired;
  logic   unused_addr_bits;

  assign gnt_o     = req_i && (state == IDLE);
  assign be_reject = STRICT_BE && we_i && (be_i != BE_FULL);
  assign wd_clear  = gnt_o && !be_reject;
  assign wd_en     = (state == ACCESS) && !pready_i;
  assign unused_addr_bits = &{1'b0, addr_i[1:0]};

  if (TIMEOUT_CYCLES > 0) begin : g_wd
    apb_watchdog_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (wd_clear),
      .en_i     (wd_en),
      .expired_o(wd_expired)
    );
  end else begin : g_no_wd
    assign wd_expired = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            paddr_o  <= {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
            pwrite_o <= we_i;
            pwdata_o <= wdata_i;
            if (be_reject) begin
              state    <= RESP;
              rvalid_o <= 1'b1;
              rdata_o  <= RDATA_ERR;
              err_o    <= 1'b1;
            end else begin
              state  <= SETUP;
              psel_o <= 1'b1;
            end
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          // A same-cycle PREADY wins over the watchdog.
          if (pready_i) begin
            state     <= RESP;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            rvalid_o  <= 1'b1;
            rdata_o   <= (pwrite_o || pslverr_i) ? RDATA_ERR : prdata_i;
            err_o     <= pslverr_i;
          end else if (wd_expired) begin
            state     <= RESP;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            rvalid_o  <= 1'b1;
            rdata_o   <= RDATA_ERR;
            err_o     <= 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          rvalid_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_apb_bridge.sv
// Directed bench for core_apb_bridge: read, stalled write, slave error, timeout, BE reject, reset.
module tb_core_apb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int n_assert = 0;
  int n_fail   = 0;

  core_apb_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8),
    .STRICT_BE     (1'b1)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .pwrite_o (pwrite_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .prdata_i (prdata_i),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are checked mid-cycle, away from the rising edge.
  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic request(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d);
    req_i   = 1'b1;
    addr_i  = a;
    we_i    = w;
    be_i    = b;
    wdata_i = d;
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    cyc(); cyc();
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_gnt", gnt_o, 0);
    rst_ni = 1'b1;

    // Zero-wait read at an unaligned address
    cyc();
    request(32'h1A10_0006, 1'b0, 4'hF, 32'h0);
    #1 chk("rd_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0; pready_i = 1'b1; prdata_i = 32'h1234_5678;
    #1 chk("rd_setup_psel", psel_o, 1);
    chk("rd_setup_penable", penable_o, 0);
    chk("rd_paddr", paddr_o, 32'h1A10_0004);
    chk("rd_pwrite", pwrite_o, 0);
    chk("rd_setup_rvalid", rvalid_o, 0);
    cyc();
    chk("rd_access_psel", psel_o, 1);
    chk("rd_access_penable", penable_o, 1);
    chk("rd_access_rvalid", rvalid_o, 0);
    cyc();
    chk("rd_resp_rvalid", rvalid_o, 1);
    chk("rd_resp_rdata", rdata_o, 32'h1234_5678);
    chk("rd_resp_err", err_o, 0);
    chk("rd_resp_psel", psel_o, 0);
    chk("rd_resp_penable", penable_o, 0);
    request(32'h0000_0010, 1'b1, 4'hF, 32'hCAFE_F00D);
    #1 chk("resp_no_gnt", gnt_o, 0);

    // Write with five PREADY wait states
    cyc();
    pready_i = 1'b0;
    #1 chk("wr_gnt", gnt_o, 1);
    chk("wr_idle_rvalid", rvalid_o, 0);
    cyc();
    req_i = 1'b0;
    #1 chk("wr_setup_psel", psel_o, 1);
    chk("wr_setup_penable", penable_o, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("wr_acc_penable", penable_o, 1);
      chk("wr_acc_psel", psel_o, 1);
      chk("wr_acc_paddr", paddr_o, 32'h0000_0010);
      chk("wr_acc_pwrite", pwrite_o, 1);
      chk("wr_acc_pwdata", pwdata_o, 32'hCAFE_F00D);
      chk("wr_acc_rvalid", rvalid_o, 0);
      if (i == 5) pready_i = 1'b1;
    end
    cyc();
    pready_i = 1'b0;
    chk("wr_resp_rvalid", rvalid_o, 1);
    chk("wr_resp_err", err_o, 0);
    chk("wr_resp_rdata", rdata_o, 0);
    chk("wr_resp_penable", penable_o, 0);

    // Slave error on a zero-wait write
    cyc();
    request(32'h0000_0020, 1'b1, 4'hF, 32'h0000_0001);
    pready_i = 1'b1; pslverr_i = 1'b1;
    #1 chk("se_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0;
    cyc();
    chk("se_access_penable", penable_o, 1);
    cyc();
    chk("se_resp_rvalid", rvalid_o, 1);
    chk("se_resp_err", err_o, 1);
    request(32'h0000_0030, 1'b0, 4'hF, 32'h0);
    #1 chk("se_resp_no_gnt", gnt_o, 0);

    // Next request granted right after RESP; it then times out after 8 ACCESS cycles
    cyc();
    pready_i = 1'b0; pslverr_i = 1'b0;
    #1 chk("to_gnt_after_resp", gnt_o, 1);
    cyc();
    req_i = 1'b0;
    #1 chk("to_setup_psel", psel_o, 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("to_acc_penable", penable_o, 1);
      chk("to_acc_rvalid", rvalid_o, 0);
    end
    cyc();
    chk("to_resp_penable", penable_o, 0);
    chk("to_resp_psel", psel_o, 0);
    chk("to_resp_rvalid", rvalid_o, 1);
    chk("to_resp_err", err_o, 1);
    chk("to_resp_rdata", rdata_o, 0);
    pready_i = 1'b1; prdata_i = 32'hDEAD_BEEF;
    cyc();
    chk("late_rdy_rvalid", rvalid_o, 0);
    chk("late_rdy_psel", psel_o, 0);
    chk("late_rdy_penable", penable_o, 0);
    chk("hold_rdata", rdata_o, 0);
    chk("hold_err", err_o, 1);
    pready_i = 1'b0;

    // Partial byte-enable write is rejected without an APB cycle
    cyc();
    request(32'h0000_0040, 1'b1, 4'h3, 32'h5555_AAAA);
    #1 chk("be_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0;
    #1 chk("be_resp_rvalid", rvalid_o, 1);
    chk("be_resp_err", err_o, 1);
    chk("be_resp_rdata", rdata_o, 0);
    chk("be_resp_psel", psel_o, 0);
    cyc();
    chk("be_idle_psel", psel_o, 0);
    chk("be_idle_rvalid", rvalid_o, 0);

    // Asynchronous reset in the middle of ACCESS
    cyc();
    request(32'h0000_0050, 1'b0, 4'hF, 32'h0);
    #1 chk("rs_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0;
    cyc();
    chk("rs_access_penable", penable_o, 1);
    #2 rst_ni = 1'b0;
    #1 chk("rs_async_psel", psel_o, 0);
    chk("rs_async_penable", penable_o, 0);
    cyc();
    rst_ni = 1'b1;
    chk("rs_rvalid", rvalid_o, 0);
    req_i = 1'b1;
    #1 chk("rs_gnt_tracks_hi", gnt_o, 1);
    req_i = 1'b0;
    #1 chk("rs_gnt_tracks_lo", gnt_o, 0);
    cyc();
    chk("rs_idle_psel", psel_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
